led_matrix_scan: RTL and testbench

Frame buffer and row-multiplexing driver for the 5x7 LED matrix, directly downstream of the row/column one-hot decoder. Accepts 35-bit pixel-enable masks (bit index row*7+col) with a write strobe and op code, accumulates them into a frame register, and scans the matrix one row at a time with a blanking gap between rows. A shadow copy is taken once per frame so the display never tears mid-scan.

---
 rtl/led_matrix_pkg.sv | 21 ++
 rtl/led_frame_buf.sv | 46 ++++
 rtl/led_matrix_scan.sv | 114 +++++++++++
 tb/tb_led_matrix_scan.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 5x7 LED matrix frame buffer and scanner.
//   ROWS/COLS/PIX : matrix geometry, pixel bit index = row*COLS + col
//   op_e          : frame update op codes carried on the 2-bit op port
//   scan_state_e  : row scanner states
package led_matrix_pkg;
  localparam int ROWS = 5;
  localparam int COLS = 7;
  localparam int PIX  = ROWS * COLS;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLR    = 2'b01,
    OP_TGL    = 2'b10,
    OP_CLRALL = 2'b11
  } op_e;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;
endpackage

// File: rtl/led_frame_buf.sv
// Frame register with set/clear/toggle/clear-all update ops plus the shadow
// copy the scanner reads from.
//   clk, rst     : clock, synchronous active-high reset
//   wr, op       : apply op to frame using pix_en as a mask
//   pix_en       : pixel mask (bit r*7+c)
//   frame_load   : overwrite frame with frame_in (wins over wr)
//   shadow_load  : copy pre-edge frame into shadow (frame boundary)
//   frame        : live frame register
//   shadow       : frame snapshot used for display
module led_frame_buf
  import led_matrix_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           wr,
  input  logic [1:0]     op,
  input  logic [PIX-1:0] pix_en,
  input  logic           frame_load,
  input  logic [PIX-1:0] frame_in,
  input  logic           shadow_load,
  output logic [PIX-1:0] frame,
  output logic [PIX-1:0] shadow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame  <= '0;
      shadow <= '0;
    end else begin
      // Nonblocking read of frame: a write on the boundary edge lands in
      // the next frame's snapshot, not this one.
      if (shadow_load) shadow <= frame;
      if (frame_load) begin
        frame <= frame_in;
      end else if (wr) begin
        case (op_e'(op))
          OP_SET:    frame <= frame | pix_en;
          OP_CLR:    frame <= frame & ~pix_en;
          OP_TGL:    frame <= frame ^ pix_en;
          default:   frame <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexing driver for a 5x7 LED matrix. Each row gets a blanking
// gap of BLANK_CYCLES followed by CLK_DIV cycles of drive; the displayed
// image comes from a shadow snapshot taken when the scan wraps 4 -> 0.
//   clk, rst            : clock, synchronous active-high reset
//   pix_en, wr, op      : masked frame update
//   frame_load, frame_in: whole-frame overwrite
//   frame               : live frame readback
//   row_n               : active-low row select (all high while blanking)
//   col                 : active-high column drive
//   row_idx             : row being scanned
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV      = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PIX-1:0]  pix_en,
  input  logic            wr,
  input  logic [1:0]      op,
  input  logic            frame_load,
  input  logic [PIX-1:0]  frame_in,
  output logic [PIX-1:0]  frame,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col,
  output logic [2:0]      row_idx
);

  localparam int MAXC  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(ROWS - 1);

  scan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       row_nxt;
  logic [ROWS-1:0]  row_n_nxt;
  logic [COLS-1:0]  col_nxt;
  logic [PIX-1:0]   shadow;
  logic             shadow_load;

  led_frame_buf u_fb (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .op         (op),
    .pix_en     (pix_en),
    .frame_load (frame_load),
    .frame_in   (frame_in),
    .shadow_load(shadow_load),
    .frame      (frame),
    .shadow     (shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      cnt     <= '0;
      row_idx <= '0;
      row_n   <= '1;
      col     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      row_idx <= row_nxt;
      row_n   <= row_n_nxt;
      col     <= col_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    row_nxt     = row_idx;
    shadow_load = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (row_idx == ROW_LAST) begin
            row_nxt     = '0;
            shadow_load = 1'b1;
          end else begin
            row_nxt = row_idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered against the next state so they switch on the
    // same edge. Shadow only changes when entering BLANK, so reading it
    // here when entering ON is stable for the whole dwell.
    row_n_nxt = '1;
    col_nxt   = '0;
    if (state_nxt == ON) begin
      row_n_nxt = ~(ROWS'(1) << row_nxt);
      col_nxt   = shadow[row_nxt*COLS +: COLS];
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;
  localparam int CD = 4;
  localparam int BC = 2;
  localparam int RP = CD + BC;
  localparam int FP = 5 * RP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        frame_load = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [34:0] pix_en = '0;
  logic [34:0] frame_in = '0;
  logic [34:0] frame;
  logic [4:0]  row_n;
  logic [6:0]  col;
  logic [2:0]  row_idx;

  always #5 clk = ~clk;

  led_matrix_scan #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .wr(wr), .op(op),
    .frame_load(frame_load), .frame_in(frame_in), .frame(frame),
    .row_n(row_n), .col(col), .row_idx(row_idx)
  );

  int npass = 0;
  int ntot = 0;
  int k = 0;                 // cycles since reset release
  logic [34:0] m_frame = '0;
  logic [34:0] m_shadow = '0;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock: update the timeline model, then compare all outputs.
  task automatic tick();
    int ph, r;
    bit on;
    logic [4:0] erow;
    logic [6:0] ecol;
    @(posedge clk);
    if (rst) begin
      m_frame = '0; m_shadow = '0; k = 0;
    end else begin
      if (k % FP == FP - 1) m_shadow = m_frame;
      if (frame_load) m_frame = frame_in;
      else if (wr) begin
        case (op)
          2'b00: m_frame = m_frame | pix_en;
          2'b01: m_frame = m_frame & ~pix_en;
          2'b10: m_frame = m_frame ^ pix_en;
          default: m_frame = '0;
        endcase
      end
      k++;
    end
    #1;
    ph = k % FP;
    r  = ph / RP;
    on = (ph % RP) >= BC;
    erow = 5'h1F;
    ecol = '0;
    if (on) begin
      erow[r] = 1'b0;
      ecol = m_shadow[r*7 +: 7];
    end
    chk("frame", frame, m_frame);
    chk("row_n", {30'd0, row_n}, {30'd0, erow});
    chk("col", {28'd0, col}, {28'd0, ecol});
    chk("row_idx", {32'd0, row_idx}, 35'(r));
  endtask

  task automatic idle();
    wr = 1'b0; frame_load = 1'b0; pix_en = '0; op = 2'b00;
  endtask

  initial begin
    // Reset held three cycles
    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_row_n", {30'd0, row_n}, 35'h1F);
    chk("rst_col", {28'd0, col}, 35'h0);
    chk("rst_frame", frame, 35'h0);
    rst = 1'b0;

    // BLANK for two cycles, then row 0 ON with empty shadow
    tick(); tick();
    chk("first_on_row_n", {30'd0, row_n}, 35'h1E);
    chk("first_on_col", {28'd0, col}, 35'h0);

    // Set pixel row1 col1; appears after next wrap
    wr = 1'b1; op = 2'b00; pix_en = 35'h100;
    tick(); idle();
    chk("set_frame", frame, 35'h100);
    while (k != FP + RP + BC) tick();
    chk("row1_row_n", {30'd0, row_n}, 35'h1D);
    chk("row1_col", {28'd0, col}, 35'h2);

    // Clear all, toggle twice
    wr = 1'b1; op = 2'b11; tick();
    wr = 1'b1; op = 2'b10; pix_en = 35'h100; tick();
    chk("tgl1", frame, 35'h100);
    tick(); idle();
    chk("tgl2", frame, 35'h0);

    // Clear-all from all-ones ignores pix_en
    frame_load = 1'b1; frame_in = '1; tick(); idle();
    wr = 1'b1; op = 2'b11; pix_en = '0; tick(); idle();
    chk("clrall", frame, 35'h0);

    // Load beats a same-cycle clear
    frame_load = 1'b1; frame_in = 35'h7_FFFF_FFFF;
    wr = 1'b1; op = 2'b01; pix_en = '1;
    tick(); idle();
    chk("load_wins", frame, 35'h7_FFFF_FFFF);
    repeat (FP) tick();
    while (k % FP != 4 * RP + BC) tick();
    chk("row4_all_on", {28'd0, col}, 35'h7F);

    // Write landing on the wrap edge is deferred one frame
    wr = 1'b1; op = 2'b11; tick(); idle();
    while (k % FP != FP - 1) tick();
    wr = 1'b1; op = 2'b00; pix_en = 35'h1;
    tick(); idle();
    while (k % FP != BC) tick();
    chk("wrap_defer_col", {28'd0, col}, 35'h0);
    repeat (FP) tick();
    chk("wrap_next_col", {28'd0, col}, 35'h1);

    // Randomized updates against the model
    repeat (400) begin
      wr = ($urandom_range(0, 1) == 1);
      op = 2'($urandom_range(0, 3));
      pix_en = 35'({$urandom(), $urandom()});
      frame_load = ($urandom_range(0, 15) == 0);
      frame_in = 35'({$urandom(), $urandom()});
      tick();
    end
    idle();

    // Reset in the middle of row 3 ON
    frame_load = 1'b1; frame_in = '1; tick(); idle();
    repeat (FP) tick();
    while (k % FP != 3 * RP + BC + 1) tick();
    chk("pre_rst_row_n", {30'd0, row_n}, 35'h17);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_row_n", {30'd0, row_n}, 35'h1F);
    chk("mid_rst_col", {28'd0, col}, 35'h0);
    chk("mid_rst_row_idx", {32'd0, row_idx}, 35'h0);
    chk("mid_rst_frame", frame, 35'h0);
    repeat (2 * FP) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
